// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_resp memory-side responder and its RAM.
package mem_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Value returned for a rejected (out-of-range) read.
  localparam logic [MEM_DW-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/ram_1p.sv
// Synchronous single-port word array; rdata is registered and only updates on a read enable.
module ram_1p #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[idx];
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// Memory-side responder: samples a request, waits WAIT cycles, accesses ram_1p, pulses Ready.
// Optional MEM_BOUNDS_EN flags addresses >= DEPTH with Err and blocks/replaces the access.
module mem_resp
  import mem_pkg::*;
#(
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW,
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] Din,
  input  logic          MRead,
  input  logic          MWrite,
  output logic [DW-1:0] Dout,
  output logic          Ready,
  output logic          Err
);

  localparam int IW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  op_e           op_q, op_d;
  logic          ready_q, ready_d;

  logic          access;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_din;
  op_e           acc_op;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_rdata;

  // With WAIT=0 the access happens on the sampling edge, so operands come straight from the ports.
  always_comb begin
    acc_addr = addr_q;
    acc_din  = din_q;
    acc_op   = op_q;
    if (state_q == ST_IDLE) begin
      acc_addr = Addr;
      acc_din  = Din;
      acc_op   = MWrite ? OP_WRITE : OP_READ;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    op_d    = op_q;
    ready_d = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MRead || MWrite) begin
          addr_d = Addr;
          din_d  = Din;
          op_d   = MWrite ? OP_WRITE : OP_READ;
          if (WAIT == 0) begin
            access  = 1'b1;
            ready_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = 4'(WAIT);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    din_q  <= din_d;
  end

`ifdef MEM_BOUNDS_EN
  logic oor;
  logic err_q, err_d;
  logic rd_oor_q, rd_oor_d;

  assign oor    = 32'(acc_addr) >= 32'(DEPTH);
  assign ram_we = access && (acc_op == OP_WRITE) && !oor;
  assign ram_re = access && (acc_op == OP_READ);

  always_comb begin
    err_d    = access && oor;
    rd_oor_d = rd_oor_q;
    if (ram_re) rd_oor_d = oor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      rd_oor_q <= rd_oor_d;
    end
  end

  // A rejected read still refreshes the RAM register; the flag masks it until the next read.
  assign Dout = rd_oor_q ? {DW{ERR_RDATA[0]}} : ram_rdata;
  assign Err  = err_q;
`else
  assign ram_we = access && (acc_op == OP_WRITE);
  assign ram_re = access && (acc_op == OP_READ);
  assign Dout   = ram_rdata;
  assign Err    = 1'b0;

  if (IW < AW) begin : g_addr_wrap
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[AW-1:IW];
  end
`endif

  ram_1p #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (acc_addr[IW-1:0]),
    .wdata (acc_din),
    .rdata (ram_rdata)
  );

  assign Ready = ready_q;

endmodule
